// File: rtl/dot_product_pkg.sv
// Shared constants and the result-narrowing helper for the streaming dot-product operator.
package dot_product_pkg;

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  localparam int MAX_ACC_W = 128;
  localparam int MAX_OUT_W = 64;

  // Returns {ovf, result}; only the low out_w bits of result are meaningful.
  function automatic logic [MAX_OUT_W:0] sat_trunc(input logic signed [MAX_ACC_W-1:0] acc,
                                                   input int unsigned out_w,
                                                   input logic sat_en);
    logic signed [MAX_ACC_W-1:0] max_v;
    logic signed [MAX_ACC_W-1:0] min_v;
    logic [MAX_OUT_W-1:0]        res;
    logic                        ovf;
    max_v = (MAX_ACC_W'(1) << (out_w - 1)) - MAX_ACC_W'(1);
    min_v = ~max_v;
    ovf   = (acc > max_v) || (acc < min_v);
    res   = acc[MAX_OUT_W-1:0];
    if (sat_en && ovf) begin
      res = (acc > max_v) ? max_v[MAX_OUT_W-1:0] : min_v[MAX_OUT_W-1:0];
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/dot_product_stream_mac.sv
// Registered signed multiply followed by a sign-extending accumulator with clear.
module dot_mac_stage #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 72
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_fire,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              prod_v
);

  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic                       prod_v_q, prod_v_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  always_comb begin
    prod_d   = prod_q;
    prod_v_d = in_fire;
    acc_d    = acc_q + (prod_v_q ? ACC_W'(prod_q) : '0);
    if (in_fire) begin
      prod_d = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
    end
    // Clear only happens on the exit cycle, when no product can be in flight.
    if (clear) begin
      acc_d    = '0;
      prod_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
    end
  end

  assign acc    = acc_q;
  assign prod_v = prod_v_q;

endmodule

// File: rtl/dot_product_stream.sv
// Joins two signed element streams, accumulates VEC_LEN products and hands the
// narrowed result plus a {ovf, seq} status word to two independent output handshakes.
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OUT_W   = 32,
  parameter int VEC_LEN = 3,
  parameter int ACC_W   = 72,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] Input_1_V_V,
  input  logic              Input_1_V_V_ap_vld,
  output logic              Input_1_V_V_ap_ack,
  input  logic [DATA_W-1:0] Input_2_V_V,
  input  logic              Input_2_V_V_ap_vld,
  output logic              Input_2_V_V_ap_ack,
  output logic [OUT_W-1:0]  Output_1_V_V,
  output logic              Output_1_V_V_ap_vld,
  input  logic              Output_1_V_V_ap_ack,
  output logic [OUT_W-1:0]  Output_2_V_V,
  output logic              Output_2_V_V_ap_vld,
  input  logic              Output_2_V_V_ap_ack
);

  localparam int               CNT_W    = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  if (ACC_W < 2*DATA_W + $clog2(VEC_LEN)) begin : g_bad_acc_w
    $error("dot_product_stream: ACC_W too narrow for DATA_W/VEC_LEN");
  end
  if (VEC_LEN < 1 || ACC_W > MAX_ACC_W || OUT_W > MAX_OUT_W || OUT_W < 2) begin : g_bad_params
    $error("dot_product_stream: unsupported VEC_LEN/ACC_W/OUT_W");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-2:0] seq_q, seq_d;
  logic             o1_vld_q, o1_vld_d;
  logic             o2_vld_q, o2_vld_d;

  logic                        in_fire;
  logic                        o1_done;
  logic                        o2_done;
  logic                        emit_exit;
  logic                        prod_v;
  logic [ACC_W-1:0]            acc;
  logic signed [MAX_ACC_W-1:0] acc_ext;
  logic [MAX_OUT_W:0]          sat_word;
  logic                        unused_sat_hi;

  assign in_fire   = (state_q == ACCUM) & ap_start & Input_1_V_V_ap_vld
                   & Input_2_V_V_ap_vld & ~ap_rst;
  assign o1_done   = ~o1_vld_q | Output_1_V_V_ap_ack;
  assign o2_done   = ~o2_vld_q | Output_2_V_V_ap_ack;
  assign emit_exit = (state_q == EMIT) & o1_done & o2_done & ~ap_rst;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    seq_d    = seq_q;
    o1_vld_d = o1_vld_q;
    o2_vld_d = o2_vld_q;
    case (state_q)
      ACCUM: begin
        if (in_fire) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d  = EMIT;
        o1_vld_d = 1'b1;
        o2_vld_d = 1'b1;
      end
      EMIT: begin
        if (o1_vld_q && Output_1_V_V_ap_ack) o1_vld_d = 1'b0;
        if (o2_vld_q && Output_2_V_V_ap_ack) o2_vld_d = 1'b0;
        if (emit_exit) begin
          state_d = ACCUM;
          count_d = '0;
          seq_d   = seq_q + 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= ACCUM;
      count_q  <= '0;
      seq_q    <= '0;
      o1_vld_q <= 1'b0;
      o2_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      o1_vld_q <= o1_vld_d;
      o2_vld_q <= o2_vld_d;
    end
  end

  dot_mac_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .clear   (emit_exit),
    .in_fire (in_fire),
    .a       (Input_1_V_V),
    .b       (Input_2_V_V),
    .acc     (acc),
    .prod_v  (prod_v)
  );

  // The accumulator is frozen throughout EMIT, so the narrowed result stays stable without a register.
  assign acc_ext       = MAX_ACC_W'($signed(acc));
  assign sat_word      = sat_trunc(acc_ext, OUT_W, SAT_EN);
  assign unused_sat_hi = ^sat_word;

  assign Output_1_V_V        = sat_word[OUT_W-1:0];
  assign Output_2_V_V        = {sat_word[MAX_OUT_W], seq_q};
  assign Output_1_V_V_ap_vld = o1_vld_q;
  assign Output_2_V_V_ap_vld = o2_vld_q;
  assign Input_1_V_V_ap_ack  = in_fire;
  assign Input_2_V_V_ap_ack  = in_fire;
  assign ap_done             = emit_exit;
  assign ap_ready            = emit_exit;
  assign ap_idle             = (state_q == ACCUM) & (count_q == '0) & ~prod_v;

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed bench for dot_product_stream: saturating and truncating instances share
// stimulus; a scoreboard queue holds expected results until each output appears.
module tb_dot_product_stream;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic        ap_rst, ap_start;
  logic [31:0] in1_data, in2_data;
  logic        in1_vld, in2_vld;
  logic        out1_ack, out2_ack;

  logic        ap_idle, ap_done, ap_ready, in1_ack, in2_ack;
  logic [31:0] o1_data, o2_data;
  logic        o1_vld, o2_vld;

  logic        t_idle, t_done, t_ready, t_in1_ack, t_in2_ack;
  logic [31:0] t_o1_data, t_o2_data;
  logic        t_o1_vld, t_o2_vld;

  typedef struct {
    logic [31:0] o1_sat;
    logic [31:0] o2_sat;
    logic [31:0] o1_trn;
    logic [31:0] o2_trn;
  } exp_t;

  exp_t              sb[$];
  exp_t              last_exp;
  logic signed [31:0] cur_a [3];
  logic signed [31:0] cur_b [3];
  int   tests_run = 0;
  int   fail_cnt  = 0;
  int   exp_seq   = 0;
  logic o1_seen   = 1'b0;
  logic o2_seen   = 1'b0;

  dot_product_stream #(
    .DATA_W(32), .OUT_W(32), .VEC_LEN(3), .ACC_W(72), .SAT_EN(1'b1)
  ) u_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
    .Input_1_V_V(in1_data), .Input_1_V_V_ap_vld(in1_vld), .Input_1_V_V_ap_ack(in1_ack),
    .Input_2_V_V(in2_data), .Input_2_V_V_ap_vld(in2_vld), .Input_2_V_V_ap_ack(in2_ack),
    .Output_1_V_V(o1_data), .Output_1_V_V_ap_vld(o1_vld), .Output_1_V_V_ap_ack(out1_ack),
    .Output_2_V_V(o2_data), .Output_2_V_V_ap_vld(o2_vld), .Output_2_V_V_ap_ack(out2_ack)
  );

  dot_product_stream #(
    .DATA_W(32), .OUT_W(32), .VEC_LEN(3), .ACC_W(72), .SAT_EN(1'b0)
  ) u_trn (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_idle(t_idle), .ap_done(t_done), .ap_ready(t_ready),
    .Input_1_V_V(in1_data), .Input_1_V_V_ap_vld(in1_vld), .Input_1_V_V_ap_ack(t_in1_ack),
    .Input_2_V_V(in2_data), .Input_2_V_V_ap_vld(in2_vld), .Input_2_V_V_ap_ack(t_in2_ack),
    .Output_1_V_V(t_o1_data), .Output_1_V_V_ap_vld(t_o1_vld), .Output_1_V_V_ap_ack(out1_ack),
    .Output_2_V_V(t_o2_data), .Output_2_V_V_ap_vld(t_o2_vld), .Output_2_V_V_ap_ack(out2_ack)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model();
    exp_t               e;
    logic signed [127:0] sum;
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    logic               ovf;
    sum   = '0;
    for (int i = 0; i < 3; i++) sum = sum + 128'(cur_a[i]) * 128'(cur_b[i]);
    max_v = 128'sd2147483647;
    min_v = -128'sd2147483648;
    ovf   = (sum > max_v) || (sum < min_v);
    e.o1_trn = sum[31:0];
    e.o1_sat = (sum > max_v) ? 32'h7FFFFFFF : (sum < min_v) ? 32'h80000000 : sum[31:0];
    e.o2_sat = {ovf, 31'(exp_seq)};
    e.o2_trn = {ovf, 31'(exp_seq)};
    return e;
  endfunction

  task automatic load_vec(input logic [31:0] a0, a1, a2, b0, b1, b2);
    cur_a[0] = a0; cur_a[1] = a1; cur_a[2] = a2;
    cur_b[0] = b0; cur_b[1] = b1; cur_b[2] = b2;
  endtask

  // Feeds pairs first..last; returns just after the final accepting edge with valids low.
  task automatic apply_stimulus(input int first, input int last);
    logic got;
    for (int i = first; i <= last; i++) begin
      in1_data = cur_a[i];
      in2_data = cur_b[i];
      in1_vld  = 1'b1;
      in2_vld  = 1'b1;
      got      = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge ap_clk);
        if (in1_ack && in2_ack) got = 1'b1;
        @(posedge ap_clk);
        #1;
      end
      check_output("pair_accept", 32'(got), 32'd1);
      if (got && i == 2) begin
        last_exp = model();
        sb.push_back(last_exp);
        exp_seq++;
      end
    end
    in1_vld = 1'b0;
    in2_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin
      @(negedge ap_clk);
      c++;
    end while (!(ap_idle && !o1_vld && !o2_vld) && c < 200);
    check_output("wait_idle", 32'({ap_idle, o1_vld, o2_vld}), 32'h4);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic pulse_reset();
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst  = 1'b0;
    sb.delete();
    o1_seen = 1'b0;
    o2_seen = 1'b0;
    exp_seq = 0;
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (o1_vld && !o1_seen) begin
        check_output("sb_has_out1", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          check_output("out1_sat", o1_data, sb[0].o1_sat);
          check_output("out1_trn", t_o1_data, sb[0].o1_trn);
        end
        o1_seen = 1'b1;
      end
      if (o2_vld && !o2_seen) begin
        check_output("sb_has_out2", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          check_output("out2_sat", o2_data, sb[0].o2_sat);
          check_output("out2_trn", t_o2_data, sb[0].o2_trn);
        end
        o2_seen = 1'b1;
      end
      if (ap_done) begin
        if (sb.size() > 0) void'(sb.pop_front());
        o1_seen = 1'b0;
        o2_seen = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ap_rst   = 1'b1;
    ap_start = 1'b1;
    in1_data = '0;
    in2_data = '0;
    in1_vld  = 1'b0;
    in2_vld  = 1'b0;
    out1_ack = 1'b1;
    out2_ack = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check_output("reset_state", 32'({ap_idle, o1_vld, o2_vld, ap_done, in1_ack, in2_ack}), 32'h20);
    @(posedge ap_clk);
    #1;

    // Basic vector with output latency and done pulse
    load_vec(1, 2, 3, 4, 5, 6);
    apply_stimulus(0, 2);
    @(negedge ap_clk);
    check_output("lat_drain", 32'({o1_vld, o2_vld}), 32'h0);
    @(negedge ap_clk);
    check_output("lat_emit", 32'({o1_vld, o2_vld, ap_done, ap_ready}), 32'hF);
    @(negedge ap_clk);
    check_output("back_idle", 32'({ap_idle, o1_vld, o2_vld}), 32'h4);
    @(posedge ap_clk);
    #1;

    // One-sided valid must never be acknowledged
    in1_data = 32'd99;
    in1_vld  = 1'b1;
    in2_vld  = 1'b0;
    repeat (5) begin
      @(negedge ap_clk);
      check_output("no_half_join", 32'({in1_ack, in2_ack, ap_idle}), 32'h1);
    end
    @(posedge ap_clk);
    #1;
    in1_vld = 1'b0;

    load_vec(-7, 2, 0, 3, -5, 9);
    apply_stimulus(0, 2);
    wait_idle();

    load_vec(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    apply_stimulus(0, 2);
    wait_idle();

    load_vec(32'h80000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    apply_stimulus(0, 2);
    wait_idle();

    // ap_start low mid-vector stalls acceptance but keeps the partial sum
    load_vec(10, -20, 30, -1, 2, 3);
    apply_stimulus(0, 0);
    ap_start = 1'b0;
    in1_data = cur_a[1];
    in2_data = cur_b[1];
    in1_vld  = 1'b1;
    in2_vld  = 1'b1;
    repeat (3) begin
      @(negedge ap_clk);
      check_output("start_low_stall", 32'({in1_ack, in2_ack, ap_idle}), 32'h0);
    end
    @(posedge ap_clk);
    #1;
    ap_start = 1'b1;
    apply_stimulus(1, 2);
    wait_idle();

    // Independent output backpressure; next pair waits for the late ack
    out2_ack = 1'b0;
    load_vec(2, 3, 4, 5, 6, 7);
    apply_stimulus(0, 2);
    load_vec(3, 3, 3, -2, -2, -2);
    in1_data = cur_a[0];
    in2_data = cur_b[0];
    in1_vld  = 1'b1;
    in2_vld  = 1'b1;
    @(negedge ap_clk);
    check_output("bp_drain_noack", 32'({in1_ack, in2_ack}), 32'h0);
    @(negedge ap_clk);
    check_output("bp_emit0", 32'({o1_vld, o2_vld, in1_ack}), 32'h6);
    for (int k = 1; k <= 3; k++) begin
      @(negedge ap_clk);
      check_output("bp_hold_flags", 32'({o1_vld, o2_vld, in1_ack, ap_done}), 32'h4);
      check_output("bp_hold_data", o2_data, last_exp.o2_sat);
    end
    @(posedge ap_clk);
    #1;
    out2_ack = 1'b1;
    @(negedge ap_clk);
    check_output("bp_exit", 32'({o2_vld, ap_done, in1_ack}), 32'h6);
    check_output("bp_exit_data", o2_data, last_exp.o2_sat);
    @(negedge ap_clk);
    check_output("bp_reaccept", 32'({in1_ack, in2_ack}), 32'h3);
    @(posedge ap_clk);
    #1;
    apply_stimulus(1, 2);
    wait_idle();

    // Reset after a partial vector discards the stale sum and seq
    load_vec(5, 5, 5, 5, 5, 5);
    apply_stimulus(0, 1);
    pulse_reset();
    @(negedge ap_clk);
    check_output("rst_partial_idle", 32'({ap_idle, o1_vld, o2_vld, ap_done}), 32'h8);
    @(posedge ap_clk);
    #1;
    load_vec(1, 1, 1, 1, 1, 1);
    apply_stimulus(0, 2);
    wait_idle();

    // Reset while a result is pending in EMIT
    out1_ack = 1'b0;
    out2_ack = 1'b0;
    load_vec(9, 9, 9, 1, 1, 1);
    apply_stimulus(0, 2);
    @(negedge ap_clk);
    @(negedge ap_clk);
    check_output("emit_pending", 32'({o1_vld, o2_vld}), 32'h3);
    @(posedge ap_clk);
    #1;
    pulse_reset();
    out1_ack = 1'b1;
    out2_ack = 1'b1;
    @(negedge ap_clk);
    check_output("rst_emit_idle", 32'({o1_vld, o2_vld, ap_done, ap_idle}), 32'h1);
    @(posedge ap_clk);
    #1;
    load_vec(-1, -1, -1, 1, 1, 1);
    apply_stimulus(0, 2);
    wait_idle();

    check_output("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
